// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the tdm_demux14 TDM receive path.
package tdm_demux_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned NCH_DEF   = 4;
    localparam int unsigned SLOT_W    = 2;
    localparam int unsigned ERRCNT_W  = 8;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/tdm_frame_ctrl.sv
// Frame alignment FSM, slot counter and pulse generation for tdm_demux14.
// Optional saturating error counter enabled by TDM_DEMUX_ERRCNT_EN.
module tdm_frame_ctrl
    import tdm_demux_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic                sync,
    output slot_t               slot,
    output logic                lock,
    output logic                err,
    output logic                frame_valid,
    output logic                sh_wr_c,
    output slot_t               sh_idx_c,
    output logic                out_load_c
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_cnt
`endif
);

    localparam slot_t LAST_SLOT = slot_t'(NCH - 1);

    state_e state_q, state_d;
    slot_t  slot_q, slot_d;
    logic   err_q, err_d;
    logic   fv_q, fv_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
            err_q   <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        err_d      = 1'b0;
        fv_d       = 1'b0;
        sh_wr_c    = 1'b0;
        sh_idx_c   = slot_q;
        out_load_c = 1'b0;
        if (valid) begin
            if (sync) begin
                // Any sync word restarts the frame at slot 0; mid-frame it is an error.
                sh_wr_c  = (state_q == LOCK) || sync;
                sh_idx_c = '0;
                slot_d   = slot_t'(1);
                state_d  = LOCK;
                err_d    = (state_q == LOCK) && (slot_q != '0);
            end else if (state_q == LOCK) begin
                if (slot_q == '0) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                    slot_d  = '0;
                end else if (slot_q == LAST_SLOT) begin
                    out_load_c = 1'b1;
                    fv_d       = 1'b1;
                    slot_d     = '0;
                end else begin
                    sh_wr_c = 1'b1;
                    slot_d  = slot_q + slot_t'(1);
                end
            end
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [ERRCNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (err_d && (cnt_q != {ERRCNT_W{1'b1}})) begin
            cnt_d = cnt_q + ERRCNT_W'(1);
        end
    end

    assign err_cnt = cnt_q;
`endif

    assign slot        = slot_q;
    assign lock        = (state_q == LOCK);
    assign err         = err_q;
    assign frame_valid = fv_q;

endmodule

// File: rtl/tdm_demux14.sv
// 4-slot TDM demultiplexer: shadow-buffers a frame and updates all channels at once.
// Define TDM_DEMUX_ERRCNT_EN to add the oErrCnt saturating error counter port.
module tdm_demux14
    import tdm_demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NCH   = NCH_DEF
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [WIDTH-1:0]    iD,
    input  logic                iValid,
    input  logic                iSync,
    output logic [WIDTH-1:0]    oY0,
    output logic [WIDTH-1:0]    oY1,
    output logic [WIDTH-1:0]    oY2,
    output logic [WIDTH-1:0]    oY3,
    output logic                oFrameValid,
    output logic [SLOT_W-1:0]   oSlot,
    output logic                oLock,
    output logic                oErr
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] oErrCnt
`endif
);

    logic  sh_wr_c;
    slot_t sh_idx_c;
    logic  out_load_c;

    logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;

    tdm_frame_ctrl #(
        .NCH (NCH)
    ) u_ctrl (
        .clk         (iClk),
        .rst         (iRst),
        .valid       (iValid),
        .sync        (iSync),
        .slot        (oSlot),
        .lock        (oLock),
        .err         (oErr),
        .frame_valid (oFrameValid),
        .sh_wr_c     (sh_wr_c),
        .sh_idx_c    (sh_idx_c),
        .out_load_c  (out_load_c)
`ifdef TDM_DEMUX_ERRCNT_EN
        ,
        .err_cnt     (oErrCnt)
`endif
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            sh0_q <= '0;
            sh1_q <= '0;
            sh2_q <= '0;
            y0_q  <= '0;
            y1_q  <= '0;
            y2_q  <= '0;
            y3_q  <= '0;
        end else begin
            sh0_q <= sh0_d;
            sh1_q <= sh1_d;
            sh2_q <= sh2_d;
            y0_q  <= y0_d;
            y1_q  <= y1_d;
            y2_q  <= y2_d;
            y3_q  <= y3_d;
        end
    end

    // Shadow write decode; the slot-3 word goes straight to channel 3 on frame load.
    always_comb begin
        sh0_d = sh0_q;
        sh1_d = sh1_q;
        sh2_d = sh2_q;
        y0_d  = y0_q;
        y1_d  = y1_q;
        y2_d  = y2_q;
        y3_d  = y3_q;
        if (sh_wr_c) begin
            case (sh_idx_c)
                slot_t'(0): sh0_d = iD;
                slot_t'(1): sh1_d = iD;
                slot_t'(2): sh2_d = iD;
                default:    ;
            endcase
        end
        if (out_load_c) begin
            y0_d = sh0_q;
            y1_d = sh1_q;
            y2_d = sh2_q;
            y3_d = iD;
        end
    end

    assign oY0 = y0_q;
    assign oY1 = y1_q;
    assign oY2 = y2_q;
    assign oY3 = y3_q;

endmodule

// File: tb/tb_tdm_demux14.sv
// Randomised and directed bench for tdm_demux14 against a queue-based frame model.
module tb_tdm_demux14;

    logic       iClk;
    logic       iRst;
    logic [3:0] iD;
    logic       iValid;
    logic       iSync;
    logic [3:0] oY0, oY1, oY2, oY3;
    logic       oFrameValid;
    logic [1:0] oSlot;
    logic       oLock;
    logic       oErr;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] oErrCnt;
`endif

    tdm_demux14 dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iD          (iD),
        .iValid      (iValid),
        .iSync       (iSync),
        .oY0         (oY0),
        .oY1         (oY1),
        .oY2         (oY2),
        .oY3         (oY3),
        .oFrameValid (oFrameValid),
        .oSlot       (oSlot),
        .oLock       (oLock),
        .oErr        (oErr)
`ifdef TDM_DEMUX_ERRCNT_EN
        ,
        .oErrCnt     (oErrCnt)
`endif
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is the list of words collected since the last sync.
    logic [3:0] part[$];
    bit         m_lock;
    logic [3:0] m_y[4];
    bit         m_fv, m_err;
    int         m_cnt;

    task automatic model(input bit r, input bit v, input bit s, input logic [3:0] d);
        m_fv  = 0;
        m_err = 0;
        if (r) begin
            part.delete();
            m_lock = 0;
            for (int i = 0; i < 4; i++) m_y[i] = '0;
            m_cnt = 0;
            return;
        end
        if (!v) return;
        if (!m_lock) begin
            if (s) begin
                m_lock = 1;
                part.delete();
                part.push_back(d);
            end
        end else if (s) begin
            if (part.size() != 0) m_err = 1;
            part.delete();
            part.push_back(d);
        end else if (part.size() == 0) begin
            m_err  = 1;
            m_lock = 0;
        end else begin
            part.push_back(d);
            if (part.size() == 4) begin
                for (int i = 0; i < 4; i++) m_y[i] = part[i];
                m_fv = 1;
                part.delete();
            end
        end
        if (m_err && m_cnt < 255) m_cnt++;
    endtask

    task automatic step(input bit r, input bit v, input bit s, input logic [3:0] d);
        @(negedge iClk);
        iRst   = r;
        iValid = v;
        iSync  = s;
        iD     = d;
        @(posedge iClk);
        model(r, v, s, d);
        #1;
        check("y0", 32'(oY0), 32'(m_y[0]));
        check("y1", 32'(oY1), 32'(m_y[1]));
        check("y2", 32'(oY2), 32'(m_y[2]));
        check("y3", 32'(oY3), 32'(m_y[3]));
        check("frame_valid", 32'(oFrameValid), 32'(m_fv));
        check("err", 32'(oErr), 32'(m_err));
        check("slot", 32'(oSlot), 32'(part.size()));
        check("lock", 32'(oLock), 32'(m_lock));
`ifdef TDM_DEMUX_ERRCNT_EN
        check("err_cnt", 32'(oErrCnt), 32'(m_cnt));
`endif
    endtask

    initial begin
        iRst = 1'b1; iValid = 1'b0; iSync = 1'b0; iD = '0;
        step(1, 0, 0, 4'h0);
        step(1, 1, 1, 4'h7);
        check("rst_y0", 32'(oY0), 32'h0);
        check("rst_lock", 32'(oLock), 32'h0);

        // Basic frame
        step(0, 1, 1, 4'h1); step(0, 1, 0, 4'h2); step(0, 1, 0, 4'h3); step(0, 1, 0, 4'h4);
        check("t1_y3", 32'(oY3), 32'h4);
        check("t1_fv", 32'(oFrameValid), 32'h1);
        step(0, 0, 0, 4'h0);
        check("t1_fv_pulse", 32'(oFrameValid), 32'h0);

        // Missing sync from slot 0 returns to HUNT, then HUNT ignores unsynced words
        step(0, 1, 0, 4'hF);
        check("t4_err", 32'(oErr), 32'h1);
        step(0, 1, 0, 4'hA); step(0, 1, 0, 4'hB);
        step(0, 1, 1, 4'h5);
        check("t2_lock", 32'(oLock), 32'h1);
        step(0, 1, 0, 4'h6); step(0, 1, 0, 4'h7); step(0, 1, 0, 4'h8);
        check("t2_y0", 32'(oY0), 32'h5);

        // Framing error mid-frame, then back-to-back frames
        step(0, 1, 1, 4'h1); step(0, 1, 0, 4'h2);
        step(0, 1, 1, 4'h9);
        check("t3_err", 32'(oErr), 32'h1);
        check("t3_hold", 32'(oY0), 32'h5);
        step(0, 1, 0, 4'hA); step(0, 1, 0, 4'hB); step(0, 1, 0, 4'hC);
        step(0, 1, 1, 4'hD);
        check("b2b_y0", 32'(oY0), 32'h9);
        step(0, 1, 0, 4'hE); step(0, 1, 0, 4'hF); step(0, 1, 0, 4'h0);

        // Gapped frame then reset after slot 2 of the next one
        step(0, 1, 1, 4'h3); step(0, 0, 0, 4'h0); step(0, 1, 0, 4'h4); step(0, 0, 1, 4'h0);
        step(0, 1, 0, 4'h5); step(0, 0, 0, 4'h0); step(0, 1, 0, 4'h6);
        check("t5_y2", 32'(oY2), 32'h5);
        step(0, 1, 1, 4'h1); step(0, 1, 0, 4'h2); step(0, 1, 0, 4'h3);
        step(1, 1, 0, 4'h4);
        check("t5_rst_y0", 32'(oY0), 32'h0);
        step(0, 0, 0, 4'h0);

`ifdef TDM_DEMUX_ERRCNT_EN
        for (int i = 0; i < 301; i++) step(0, 1, 1, 4'(i));
        check("t6_sat", 32'(oErrCnt), 32'd255);
        step(1, 0, 0, 4'h0);
        check("t6_clr", 32'(oErrCnt), 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
